// File: rtl/router_fsm_nch.sv
// Packet router control FSM for NUM_CH output FIFOs, with a bounded wait for an empty
// destination FIFO and a drop path for out-of-range header addresses.
module router_fsm_nch #(
    parameter int NUM_CH     = 3,
    parameter int ADDR_W     = 2,
    parameter int WAIT_LIMIT = 30,
    parameter int CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic [NUM_CH-1:0] dest_sel,
    output logic              drop_state,
    output logic              wait_timeout,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int NADDR  = 2**ADDR_W;
    localparam int WCNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    typedef enum logic [3:0] {
        S_DECODE, S_LFD, S_LD, S_FULL, S_LAF, S_LP, S_CPE, S_WAIT, S_DROP
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic                r_wait_timeout;

    logic [NADDR-1:0]    w_empty_pad;
    logic [NADDR-1:0]    w_srst_pad;
    logic [NADDR-1:0]    w_onehot;
    logic                w_addr_ok;
    logic                w_soft_rst;
    logic                w_wait_expired;
    logic [CNT_W-1:0]    w_drop_nxt;

    // Flags are zero-extended to the full address space so any address indexes safely.
    assign w_empty_pad    = NADDR'(fifo_empty);
    assign w_srst_pad     = NADDR'(soft_reset);
    assign w_onehot       = NADDR'(1) << r_addr;
    assign w_addr_ok      = (int'(data_in) < NUM_CH);
    assign w_soft_rst     = w_srst_pad[r_addr] && (r_state != S_DECODE) && (r_state != S_DROP);
    assign w_wait_expired = (WAIT_LIMIT != 0) && (r_wait_cnt == WCNT_W'(WAIT_LIMIT - 1));
    assign w_drop_nxt     = (r_drop_cnt == '1) ? r_drop_cnt : r_drop_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_DECODE;
            r_addr         <= '0;
            r_wait_cnt     <= '0;
            r_drop_cnt     <= '0;
            r_wait_timeout <= 1'b0;
        end else begin
            r_wait_timeout <= 1'b0;
            r_wait_cnt     <= '0;
            if (r_state == S_DECODE)
                r_addr <= data_in;
            if (w_soft_rst) begin
                r_state <= S_DECODE;
            end else begin
                case (r_state)
                    S_DECODE: begin
                        if (pkt_valid) begin
                            if (!w_addr_ok) begin
                                r_state    <= S_DROP;
                                r_drop_cnt <= w_drop_nxt;
                            end else if (w_empty_pad[data_in]) begin
                                r_state <= S_LFD;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (w_empty_pad[r_addr]) begin
                            r_state <= S_LFD;
                        end else if (w_wait_expired) begin
                            r_state        <= S_DROP;
                            r_drop_cnt     <= w_drop_nxt;
                            r_wait_timeout <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    S_LFD:  r_state <= S_LD;
                    S_LD: begin
                        if (fifo_full)       r_state <= S_FULL;
                        else if (!pkt_valid) r_state <= S_LP;
                    end
                    S_FULL: begin
                        if (!fifo_full) r_state <= S_LAF;
                    end
                    S_LAF: begin
                        if (parity_done)        r_state <= S_DECODE;
                        else if (low_pkt_valid) r_state <= S_LP;
                        else                    r_state <= S_LD;
                    end
                    S_LP:   r_state <= S_CPE;
                    S_CPE:  r_state <= fifo_full ? S_FULL : S_DECODE;
                    S_DROP: begin
                        if (!pkt_valid) r_state <= S_DECODE;
                    end
                    default: r_state <= S_DECODE;
                endcase
            end
        end
    end

    assign detect_add    = (r_state == S_DECODE);
    assign lfd_state     = (r_state == S_LFD);
    assign ld_state      = (r_state == S_LD);
    assign full_state    = (r_state == S_FULL);
    assign laf_state     = (r_state == S_LAF);
    assign drop_state    = (r_state == S_DROP);
    assign write_enb_reg = (r_state == S_LD) || (r_state == S_LP) || (r_state == S_LAF);
    assign rst_int_reg   = (r_state == S_CPE) && !low_pkt_valid;
    assign busy          = !((r_state == S_DECODE) || (r_state == S_LD) || (r_state == S_DROP));
    assign dest_sel      = ((r_state == S_DECODE) || (r_state == S_DROP)) ? '0 : NUM_CH'(w_onehot);
    assign wait_timeout  = r_wait_timeout;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_router_fsm_nch.sv
// Directed bench for router_fsm_nch (3 channels, 2-bit address so address 3 is invalid,
// 30-cycle wait limit, 2-bit drop counter to reach saturation quickly).
module tb_router_fsm_nch;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 2;
    localparam int WLIM   = 30;
    localparam int CNT_W  = 2;

    localparam int DEC = 0, LFD = 1, LD = 2, FUL = 3, LAF = 4, LP = 5, CPE = 6, WT = 7, DRP = 8;

    logic              clock = 1'b0;
    logic              reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_empty, soft_reset;
    logic              detect_add, lfd_state, ld_state, full_state, laf_state, write_enb_reg;
    logic              rst_int_reg, busy, drop_state, wait_timeout;
    logic [NUM_CH-1:0] dest_sel;
    logic [CNT_W-1:0]  drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_LIMIT(WLIM), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .dest_sel(dest_sel),
        .drop_state(drop_state), .wait_timeout(wait_timeout), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    // {detect_add, lfd, ld, full, laf, drop, write_enb, busy} expected in each state
    function automatic logic [7:0] flags(input int st);
        case (st)
            DEC:     return 8'b1000_0000;
            LFD:     return 8'b0100_0001;
            LD:      return 8'b0010_0010;
            FUL:     return 8'b0001_0001;
            LAF:     return 8'b0000_1011;
            LP:      return 8'b0000_0011;
            CPE:     return 8'b0000_0001;
            WT:      return 8'b0000_0001;
            DRP:     return 8'b0000_0100;
            default: return 8'hxx;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int st, input logic [NUM_CH-1:0] dsel,
                       input logic wto, input logic rint, input logic [CNT_W-1:0] dcnt);
        logic [14:0] obs, exp;
        obs = {detect_add, lfd_state, ld_state, full_state, laf_state, drop_state,
               write_enb_reg, busy, dest_sel, wait_timeout, rst_int_reg, drop_cnt};
        exp = {flags(st), dsel, wto, rint, dcnt};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
        tick(); tick();
        chk("reset", DEC, 3'b000, 0, 0, 2'd0);
        reset = 1'b0;
        tick();
        chk("idle", DEC, 3'b000, 0, 0, 2'd0);

        // Normal packet to channel 2
        pkt_valid = 1'b1; data_in = 2'd2;
        tick(); chk("t1_lfd", LFD, 3'b100, 0, 0, 2'd0);
        tick(); chk("t1_ld", LD, 3'b100, 0, 0, 2'd0);
        tick(); chk("t1_ld2", LD, 3'b100, 0, 0, 2'd0);
        pkt_valid = 1'b0;
        tick(); chk("t1_lp", LP, 3'b100, 0, 0, 2'd0);
        tick(); chk("t1_cpe", CPE, 3'b100, 0, 1, 2'd0);
        tick(); chk("t1_dec", DEC, 3'b000, 0, 0, 2'd0);

        // Channel 1 busy for 5 cycles, then empties
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
        for (int i = 0; i < 5; i++) begin
            tick(); chk("t2_wait", WT, 3'b010, 0, 0, 2'd0);
        end
        fifo_empty = 3'b111;
        tick(); chk("t2_lfd", LFD, 3'b010, 0, 0, 2'd0);
        tick(); chk("t2_ld", LD, 3'b010, 0, 0, 2'd0);
        pkt_valid = 1'b0;
        tick(); chk("t2_lp", LP, 3'b010, 0, 0, 2'd0);
        tick(); chk("t2_cpe", CPE, 3'b010, 0, 1, 2'd0);
        tick(); chk("t2_dec", DEC, 3'b000, 0, 0, 2'd0);

        // Channel 2 never empties: 30 wait cycles then timeout drop
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
        for (int i = 0; i < WLIM; i++) begin
            tick(); chk("t3_wait", WT, 3'b100, 0, 0, 2'd0);
        end
        tick(); chk("t3_drop", DRP, 3'b000, 1, 0, 2'd1);
        tick(); chk("t3_drop2", DRP, 3'b000, 0, 0, 2'd1);
        pkt_valid = 1'b0; fifo_empty = 3'b111;
        tick(); chk("t3_dec", DEC, 3'b000, 0, 0, 2'd1);

        // Invalid address 3 is discarded
        pkt_valid = 1'b1; data_in = 2'd3;
        tick(); chk("t4_drop", DRP, 3'b000, 0, 0, 2'd2);
        tick(); chk("t4_drop2", DRP, 3'b000, 0, 0, 2'd2);
        pkt_valid = 1'b0;
        tick(); chk("t4_dec", DEC, 3'b000, 0, 0, 2'd2);

        // Full handling, low_pkt_valid path, soft resets on ch0 (ignored) and ch2
        pkt_valid = 1'b1; data_in = 2'd2;
        tick(); chk("t5_lfd", LFD, 3'b100, 0, 0, 2'd2);
        tick(); chk("t5_ld", LD, 3'b100, 0, 0, 2'd2);
        fifo_full = 1'b1;
        tick(); chk("t5_full", FUL, 3'b100, 0, 0, 2'd2);
        soft_reset = 3'b001;
        tick(); chk("t5_srst0", FUL, 3'b100, 0, 0, 2'd2);
        soft_reset = 3'b000; fifo_full = 1'b0;
        tick(); chk("t5_laf", LAF, 3'b100, 0, 0, 2'd2);
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        tick(); chk("t5_lp", LP, 3'b100, 0, 0, 2'd2);
        tick(); chk("t5_cpe_low", CPE, 3'b100, 0, 0, 2'd2);
        low_pkt_valid = 1'b0;
        tick(); chk("t5_dec", DEC, 3'b000, 0, 0, 2'd2);
        pkt_valid = 1'b1;
        tick(); chk("t5b_lfd", LFD, 3'b100, 0, 0, 2'd2);
        tick(); chk("t5b_ld", LD, 3'b100, 0, 0, 2'd2);
        soft_reset = 3'b100;
        tick(); chk("t5b_srst2", DEC, 3'b000, 0, 0, 2'd2);
        soft_reset = 3'b000; pkt_valid = 1'b0;
        tick(); chk("t5b_dec", DEC, 3'b000, 0, 0, 2'd2);

        // LAF->LD, CPE->FULL, LAF with parity_done -> DEC (channel 1)
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(); chk("p_lfd", LFD, 3'b010, 0, 0, 2'd2);
        tick(); chk("p_ld", LD, 3'b010, 0, 0, 2'd2);
        fifo_full = 1'b1;
        tick(); chk("p_full", FUL, 3'b010, 0, 0, 2'd2);
        fifo_full = 1'b0;
        tick(); chk("p_laf", LAF, 3'b010, 0, 0, 2'd2);
        tick(); chk("p_laf_ld", LD, 3'b010, 0, 0, 2'd2);
        pkt_valid = 1'b0;
        tick(); chk("p_lp", LP, 3'b010, 0, 0, 2'd2);
        fifo_full = 1'b1;
        tick(); chk("p_cpe", CPE, 3'b010, 0, 1, 2'd2);
        tick(); chk("p_cpe_full", FUL, 3'b010, 0, 0, 2'd2);
        fifo_full = 1'b0;
        tick(); chk("p_laf2", LAF, 3'b010, 0, 0, 2'd2);
        parity_done = 1'b1;
        tick(); chk("p_pdone", DEC, 3'b000, 0, 0, 2'd2);
        parity_done = 1'b0;

        // Three more drops: counter saturates at 3 after five drops in total
        for (int k = 0; k < 3; k++) begin
            pkt_valid = 1'b1; data_in = 2'd3;
            tick(); chk("t6_sat_drop", DRP, 3'b000, 0, 0, 2'd3);
            pkt_valid = 1'b0;
            tick(); chk("t6_sat_dec", DEC, 3'b000, 0, 0, 2'd3);
        end

        // Reset in the middle of a packet
        pkt_valid = 1'b1; data_in = 2'd0;
        tick(); chk("t6_lfd", LFD, 3'b001, 0, 0, 2'd3);
        tick(); chk("t6_ld", LD, 3'b001, 0, 0, 2'd3);
        reset = 1'b1;
        tick(); chk("t6_reset", DEC, 3'b000, 0, 0, 2'd0);
        reset = 1'b0; pkt_valid = 1'b0;
        tick(); chk("t6_after", DEC, 3'b000, 0, 0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
